// File: rtl/bce_column_sequencer.sv
// Job sequencer for a single bit-column engine: issues the sign column, then the magnitude columns,
// drains the engine pipeline and returns the accumulated result. Build option macro: ZERO_SKIP_EN.
module bce_column_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int RESULT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [63:0]         job_act,
    input  logic [63:0]         job_wgt,
    output logic [63:0]         bce_activations,
    output logic [7:0]          bce_weight_column,
    output logic                bce_weight_sign_en,
    output logic [2:0]          bce_shift_offset,
    output logic                bce_done,
    input  logic [RESULT_W-1:0] bce_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_result,
    output logic [2:0]          out_cols
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SIGN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [63:0]           act_r;
    logic [63:0]           act_s;
    logic [63:0]           wgt_r;
    logic [63:0]           wgt_s;
    logic [6:0]            mask_r;
    logic [6:0]            mask_s;
    logic [2:0]            cols_r;
    logic [2:0]            cols_s;
    logic [DRAIN_W-1:0]    drain_r;
    logic [DRAIN_W-1:0]    drain_s;
    logic [RESULT_W-1:0]   result_r;
    logic [RESULT_W-1:0]   result_s;
    logic                  valid_r;
    logic                  valid_s;
    logic                  done_r;
    logic                  done_s;
    logic [7:0]            col_r;
    logic [7:0]            col_s;
    logic                  sign_en_r;
    logic                  sign_en_s;
    logic [2:0]            shift_r;
    logic [2:0]            shift_s;
    logic                  job_ready_r;
    logic                  job_ready_s;
    logic [2:0]            pick_s;

    // Gathers bit position bit_idx of every lane weight into one 8-bit column.
    function automatic logic [7:0] column_of(input logic [63:0] wgt, input logic [2:0] bit_idx);
        logic [7:0] col;
        logic [7:0] lane;
        col = 8'h00;
        for (int k = 0; k < 8; k++) begin
            lane   = wgt[8*k +: 8];
            col[k] = lane[bit_idx];
        end
        return col;
    endfunction

    // Magnitude columns that must be issued for this weight set.
    function automatic logic [6:0] build_mask(input logic [63:0] wgt);
        logic [6:0] mask;
`ifdef ZERO_SKIP_EN
        mask = 7'h00;
        for (int j = 0; j < 7; j++) begin
            mask[j] = |column_of(wgt, 3'(j));
        end
`else
        mask = 7'h7F;
        if (wgt == 64'h0) begin
            mask = 7'h7F;
        end else begin
            mask = 7'h7F;
        end
`endif
        return mask;
    endfunction

    // Index of the lowest set bit; 0 for an empty mask (never used in that case).
    function automatic logic [2:0] lowest_set(input logic [6:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int j = 6; j >= 0; j--) begin
            if (mask[j]) begin
                idx = 3'(j);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next-state and next-output computation; outputs are registered from these values.
    always_comb begin
        pick_s    = lowest_set(mask_r);
        state_s   = state_r;
        act_s     = act_r;
        wgt_s     = wgt_r;
        mask_s    = mask_r;
        cols_s    = cols_r;
        drain_s   = drain_r;
        result_s  = result_r;
        valid_s   = valid_r;
        done_s    = 1'b0;
        col_s     = 8'h00;
        sign_en_s = 1'b0;
        shift_s   = 3'd0;

        case (state_r)
            ST_IDLE: begin
                if (job_valid && job_ready_r) begin
                    act_s     = job_act;
                    wgt_s     = job_wgt;
                    mask_s    = build_mask(job_wgt);
                    cols_s    = 3'd0;
                    col_s     = column_of(job_wgt, 3'd7);
                    sign_en_s = 1'b1;
                    state_s   = ST_SIGN;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            // SIGN and ISSUE share the same successor logic: issue the next column or drain.
            ST_SIGN, ST_ISSUE: begin
                if (mask_r != 7'h00) begin
                    col_s   = column_of(wgt_r, pick_s);
                    shift_s = pick_s;
                    mask_s  = mask_r & ~(7'h01 << pick_s);
                    cols_s  = cols_r + 3'd1;
                    state_s = ST_ISSUE;
                end else begin
                    drain_s = {DRAIN_W{1'b0}};
                    state_s = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    result_s = bce_result;
                    valid_s  = 1'b1;
                    done_s   = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    drain_s  = drain_r + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                if (valid_r && out_ready) begin
                    valid_s = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    valid_s = valid_r;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase

        job_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers; reset discards any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            act_r       <= 64'h0;
            wgt_r       <= 64'h0;
            mask_r      <= 7'h00;
            cols_r      <= 3'd0;
            drain_r     <= {DRAIN_W{1'b0}};
            result_r    <= {RESULT_W{1'b0}};
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
            col_r       <= 8'h00;
            sign_en_r   <= 1'b0;
            shift_r     <= 3'd0;
            job_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            act_r       <= act_s;
            wgt_r       <= wgt_s;
            mask_r      <= mask_s;
            cols_r      <= cols_s;
            drain_r     <= drain_s;
            result_r    <= result_s;
            valid_r     <= valid_s;
            done_r      <= done_s;
            col_r       <= col_s;
            sign_en_r   <= sign_en_s;
            shift_r     <= shift_s;
            job_ready_r <= job_ready_s;
        end
    end

    assign job_ready          = job_ready_r;
    assign bce_activations    = act_r;
    assign bce_weight_column  = col_r;
    assign bce_weight_sign_en = sign_en_r;
    assign bce_shift_offset   = shift_r;
    assign bce_done           = done_r;
    assign out_valid          = valid_r;
    assign out_result         = result_r;
    assign out_cols           = cols_r;

endmodule

// File: tb/tb_bce_column_sequencer.sv
// Directed self-checking bench for bce_column_sequencer; expectations follow the
// ZERO_SKIP_EN setting of the build.
module tb_bce_column_sequencer;

    localparam int D  = 2;
    localparam int RW = 16;
`ifdef ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic [63:0]   job_act;
    logic [63:0]   job_wgt;
    logic [63:0]   bce_activations;
    logic [7:0]    bce_weight_column;
    logic          bce_weight_sign_en;
    logic [2:0]    bce_shift_offset;
    logic          bce_done;
    logic [RW-1:0] bce_result;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_result;
    logic [2:0]    out_cols;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]    log_col   [0:47];
    logic [2:0]    log_shift [0:47];
    logic          log_sign  [0:47];
    logic          log_done  [0:47];
    logic          log_valid [0:47];
    logic          log_jr    [0:47];
    logic [RW-1:0] log_res   [0:47];
    logic [2:0]    log_cols  [0:47];
    logic [63:0]   log_act   [0:47];
    int first_v;
    int last_k;
    int n_done;
    int n_valid;

    bce_column_sequencer #(.DRAIN_CYCLES(D), .RESULT_W(RW)) dut (
        .clk                (clk),
        .rst                (rst),
        .job_valid          (job_valid),
        .job_ready          (job_ready),
        .job_act            (job_act),
        .job_wgt            (job_wgt),
        .bce_activations    (bce_activations),
        .bce_weight_column  (bce_weight_column),
        .bce_weight_sign_en (bce_weight_sign_en),
        .bce_shift_offset   (bce_shift_offset),
        .bce_done           (bce_done),
        .bce_result         (bce_result),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_result         (out_result),
        .out_cols           (out_cols)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Offer a job from a negedge and return once it has been taken at a posedge.
    task automatic accept(input logic [63:0] act, input logic [63:0] wgt, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        job_act   = act;
        job_wgt   = wgt;
        job_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (job_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 job_valid = 1'b0;
    endtask

    // Log outputs every cycle after an accept; out_ready rises after 'hold' valid cycles.
    task automatic collect(input int hold);
        int vcnt;
        vcnt    = 0;
        first_v = -1;
        last_k  = -1;
        n_done  = 0;
        for (int k = 0; k < 48; k++) begin
            log_col[k] = 8'hxx; log_shift[k] = 3'bxxx; log_sign[k] = 1'bx;
            log_done[k] = 1'bx; log_valid[k] = 1'bx; log_jr[k] = 1'bx;
            log_res[k] = 16'hxxxx; log_cols[k] = 3'bxxx; log_act[k] = 64'hx;
        end
        out_ready = 1'b0;
        for (int k = 1; k < 48; k++) begin
            @(negedge clk);
            log_col[k]   = bce_weight_column;
            log_shift[k] = bce_shift_offset;
            log_sign[k]  = bce_weight_sign_en;
            log_done[k]  = bce_done;
            log_valid[k] = out_valid;
            log_jr[k]    = job_ready;
            log_res[k]   = out_result;
            log_cols[k]  = out_cols;
            log_act[k]   = bce_activations;
            if (bce_done === 1'b1) n_done++;
            if (out_valid === 1'b1 && last_k < 0) begin
                vcnt++;
                if (first_v < 0) begin
                    first_v    = k;
                    bce_result = ~bce_result;
                end
                if (vcnt > hold) out_ready = 1'b1;
                if (out_ready === 1'b1) last_k = k;
            end
            if (last_k > 0 && k == last_k + 1) break;
        end
        n_valid   = vcnt;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (job_ready !== 1'b0) begin
            n_fails++; $display("FAIL reset_job_ready: got %b want 0", job_ready);
        end
        n_checks++;
        if ({bce_activations, bce_weight_column, bce_weight_sign_en, bce_shift_offset,
             bce_done, out_valid, out_result, out_cols} !== 97'h0) begin
            n_fails++; $display("FAIL reset_outputs: got act=%h col=%h sign=%b sh=%0d done=%b v=%b res=%h cols=%0d want all 0",
                bce_activations, bce_weight_column, bce_weight_sign_en, bce_shift_offset, bce_done, out_valid, out_result, out_cols);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (job_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++; $display("FAIL idle_after_reset: job_ready=%b out_valid=%b want 1/0", job_ready, out_valid);
        end
    endtask

    task automatic test_single_column;
        bit ok;
        int nexp;
        logic [2:0] esh;
        logic [7:0] ecol;
        nexp = ZS ? 1 : 7;
        bce_result = 16'h3C5A;
        accept(64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL single_accept: job not accepted within budget"); end
        collect(0);
        n_checks++;
        if ({log_sign[1], log_col[1], log_shift[1], log_jr[1]} !== {1'b1, 8'h00, 3'd0, 1'b0}) begin
            n_fails++; $display("FAIL single_sign: got sign=%b col=%h sh=%0d jr=%b want 1 00 0 0",
                log_sign[1], log_col[1], log_shift[1], log_jr[1]);
        end
        n_checks++;
        if (log_act[1] !== 64'h0101_0101_0101_0101) begin
            n_fails++; $display("FAIL single_act: got %h want 0101010101010101", log_act[1]);
        end
        for (int i = 0; i < nexp; i++) begin
            esh  = ZS ? 3'd0 : 3'(i);
            ecol = (esh == 3'd0) ? 8'hFF : 8'h00;
            n_checks++;
            if ({log_sign[2+i], log_col[2+i], log_shift[2+i]} !== {1'b0, ecol, esh}) begin
                n_fails++; $display("FAIL single_issue%0d: got sign=%b col=%h sh=%0d want 0 %h %0d",
                    i, log_sign[2+i], log_col[2+i], log_shift[2+i], ecol, esh);
            end
        end
        n_checks++;
        if ({log_sign[2+nexp], log_col[2+nexp], log_shift[2+nexp]} !== 12'h0) begin
            n_fails++; $display("FAIL single_drain_quiet: got col=%h sh=%0d sign=%b want 0",
                log_col[2+nexp], log_shift[2+nexp], log_sign[2+nexp]);
        end
        n_checks++;
        if (first_v != 2 + nexp + D) begin
            n_fails++; $display("FAIL single_latency: out_valid at T+%0d want T+%0d", first_v, 2 + nexp + D);
        end
        if (first_v > 0) begin
            n_checks++;
            if (log_cols[first_v] !== 3'(nexp) || log_res[first_v] !== 16'h3C5A) begin
                n_fails++; $display("FAIL single_result: got cols=%0d res=%h want %0d 3c5a",
                    log_cols[first_v], log_res[first_v], nexp);
            end
            n_checks++;
            if (n_done != 1 || log_done[first_v] !== 1'b1) begin
                n_fails++; $display("FAIL single_done: pulses=%0d at_first=%b want 1 1", n_done, log_done[first_v]);
            end
        end
    endtask

    task automatic test_zero_weights;
        bit ok;
        int nexp;
        logic [63:0] wgts  [0:1];
        logic [7:0]  signs [0:1];
        wgts[0]  = 64'h0;
        wgts[1]  = 64'h8080_8080_8080_8080;
        signs[0] = 8'h00;
        signs[1] = 8'hFF;
        nexp = ZS ? 0 : 7;
        for (int t = 0; t < 2; t++) begin
            bce_result = (t == 0) ? 16'h1357 : 16'h8001;
            accept(64'h2222_3333_4444_5555, wgts[t], ok);
            n_checks++;
            if (!ok) begin n_fails++; $display("FAIL zero%0d_accept: job not accepted within budget", t); end
            collect(0);
            n_checks++;
            if ({log_sign[1], log_col[1]} !== {1'b1, signs[t]}) begin
                n_fails++; $display("FAIL zero%0d_sign: got sign=%b col=%h want 1 %h", t, log_sign[1], log_col[1], signs[t]);
            end
            for (int i = 0; i < nexp; i++) begin
                n_checks++;
                if ({log_col[2+i], log_shift[2+i]} !== {8'h00, 3'(i)}) begin
                    n_fails++; $display("FAIL zero%0d_issue%0d: got col=%h sh=%0d want 00 %0d", t, i, log_col[2+i], log_shift[2+i], i);
                end
            end
            n_checks++;
            if (first_v != 2 + nexp + D) begin
                n_fails++; $display("FAIL zero%0d_latency: out_valid at T+%0d want T+%0d", t, first_v, 2 + nexp + D);
            end
            if (first_v > 0) begin
                n_checks++;
                if (log_cols[first_v] !== 3'(nexp) || log_res[first_v] !== ((t == 0) ? 16'h1357 : 16'h8001)) begin
                    n_fails++; $display("FAIL zero%0d_result: got cols=%0d res=%h want %0d", t, log_cols[first_v], log_res[first_v], nexp);
                end
            end
        end
    endtask

    task automatic test_sparse;
        bit ok;
        int nexp;
        logic [2:0] esh;
        logic [7:0] ecol;
        logic [2:0] zs_sh  [0:2];
        logic [7:0] ns_col [0:6];
        zs_sh  = '{3'd0, 3'd2, 3'd6};
        ns_col = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        nexp = ZS ? 3 : 7;
        bce_result = 16'h4242;
        accept(64'h0807_0605_0403_0201, 64'h0000_0000_0000_0045, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL sparse_accept: job not accepted within budget"); end
        collect(0);
        for (int i = 0; i < nexp; i++) begin
            esh  = ZS ? zs_sh[i] : 3'(i);
            ecol = ZS ? 8'h01 : ns_col[i];
            n_checks++;
            if ({log_sign[2+i], log_col[2+i], log_shift[2+i]} !== {1'b0, ecol, esh}) begin
                n_fails++; $display("FAIL sparse_issue%0d: got sign=%b col=%h sh=%0d want 0 %h %0d",
                    i, log_sign[2+i], log_col[2+i], log_shift[2+i], ecol, esh);
            end
        end
        n_checks++;
        if (first_v != 2 + nexp + D) begin
            n_fails++; $display("FAIL sparse_latency: out_valid at T+%0d want T+%0d", first_v, 2 + nexp + D);
        end
        if (first_v > 0) begin
            n_checks++;
            if (log_cols[first_v] !== 3'(nexp)) begin
                n_fails++; $display("FAIL sparse_cols: got %0d want %0d", log_cols[first_v], nexp);
            end
        end
    endtask

    task automatic test_hold_output;
        bit ok;
        int nexp;
        nexp = ZS ? 1 : 7;
        bce_result = 16'hBEEF;
        accept(64'hFEDC_BA98_7654_3210, 64'h0101_0101_0101_0101, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL hold_accept: job not accepted within budget"); end
        collect(5);
        n_checks++;
        if (n_valid != 6 || last_k != first_v + 5) begin
            n_fails++; $display("FAIL hold_valid_len: got %0d valid cycles, accept at +%0d want 6 +5", n_valid, last_k - first_v);
        end
        if (first_v > 0) begin
            for (int k = first_v; k <= first_v + 5; k++) begin
                n_checks++;
                if ({log_valid[k], log_res[k], log_cols[k], log_jr[k], log_done[k]} !==
                    {1'b1, 16'hBEEF, 3'(nexp), 1'b0, (k == first_v)}) begin
                    n_fails++; $display("FAIL hold_cycle%0d: got v=%b res=%h cols=%0d jr=%b done=%b want 1 beef %0d 0 %b",
                        k - first_v, log_valid[k], log_res[k], log_cols[k], log_jr[k], log_done[k], nexp, (k == first_v));
                end
            end
            n_checks++;
            if ({log_valid[first_v+6], log_jr[first_v+6]} !== 2'b01) begin
                n_fails++; $display("FAIL hold_release: got v=%b jr=%b want 0 1", log_valid[first_v+6], log_jr[first_v+6]);
            end
        end
        n_checks++;
        if (n_done != 1) begin
            n_fails++; $display("FAIL hold_done_count: got %0d want 1", n_done);
        end
    endtask

    task automatic test_reset_mid_job;
        bit ok;
        bit saw;
        int nexp;
        bce_result = 16'h0F0F;
        accept(64'h1111_1111_1111_1111, 64'h0000_0000_0000_0045, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL rstjob_accept: job not accepted within budget"); end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bce_weight_column, bce_shift_offset} !== (ZS ? {8'h01, 3'd2} : {8'h00, 3'd1})) begin
            n_fails++; $display("FAIL rstjob_second_issue: got col=%h sh=%0d", bce_weight_column, bce_shift_offset);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({job_ready, bce_activations, bce_weight_column, bce_weight_sign_en, bce_shift_offset,
             bce_done, out_valid, out_result, out_cols} !== 98'h0) begin
            n_fails++; $display("FAIL rstjob_clear: got jr=%b act=%h col=%h sh=%0d v=%b cols=%0d want all 0",
                job_ready, bce_activations, bce_weight_column, bce_shift_offset, out_valid, out_cols);
        end
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || bce_done !== 1'b0) saw = 1'b1;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || bce_done !== 1'b0) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fails++; $display("FAIL rstjob_no_result: got out_valid/bce_done activity for discarded job, want none");
        end
        nexp = ZS ? 1 : 7;
        bce_result = 16'h7777;
        accept(64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL rstjob_reaccept: job not accepted within budget"); end
        collect(0);
        n_checks++;
        if (first_v != 2 + nexp + D) begin
            n_fails++; $display("FAIL rstjob_latency: out_valid at T+%0d want T+%0d", first_v, 2 + nexp + D);
        end
        if (first_v > 0) begin
            n_checks++;
            if ({log_res[first_v], log_cols[first_v]} !== {16'h7777, 3'(nexp)} || n_done != 1) begin
                n_fails++; $display("FAIL rstjob_result: got res=%h cols=%0d done=%0d want 7777 %0d 1",
                    log_res[first_v], log_cols[first_v], n_done, nexp);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_act    = 64'h0;
        job_wgt    = 64'h0;
        bce_result = 16'h0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_column();
        test_zero_weights();
        test_sparse();
        test_hold_output();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
